// File: rtl/rv_dmem_resp.sv
// Word-addressed data memory responder with a req/ready handshake, fixed wait states
// and an error flag for misaligned or out-of-range accesses. Optional byte-lane
// stores are enabled by defining RV_DMEM_BYTE_EN_EN.
module rv_dmem_resp #(
    parameter int DPWIDTH     = 32,
    parameter int MEMWORDS    = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dmem_req,
    input  logic               dmem_we,
    input  logic [DPWIDTH-1:0] dmem_addr,
    input  logic [DPWIDTH-1:0] dmem_dataout,
`ifdef RV_DMEM_BYTE_EN_EN
    input  logic [3:0]         dmem_be,
`endif
    output logic [DPWIDTH-1:0] dmem_datain,
    output logic               dmem_ready,
    output logic               dmem_err,
    output logic [1:0]         dbg_state
);

    localparam int AW = $clog2(MEMWORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [DPWIDTH-1:0] ADDR_LIMIT = DPWIDTH'(64'(4) * 64'(MEMWORDS));
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    // Handshake: dmem_req is sampled only in IDLE; dmem_ready is a one-cycle
    // strobe per accepted request, and dmem_err/dmem_datain are valid with it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [DPWIDTH-1:0] addr_q;
    logic [DPWIDTH-1:0] wdata_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [3:0]         be_in;

    logic [DPWIDTH-1:0] mem [MEMWORDS];

    logic [DPWIDTH-1:0] c_addr;
    logic [DPWIDTH-1:0] c_wdata;
    logic               c_we;
    logic [3:0]         c_be;
    logic [AW-1:0]      c_idx;
    logic               c_err;
    logic               complete;

`ifdef RV_DMEM_BYTE_EN_EN
    assign be_in = dmem_be;
`else
    assign be_in = 4'hF;
`endif

    assign dbg_state = state;

    // With zero wait states the access completes on its acceptance edge, so the
    // live inputs stand in for the not-yet-captured registers.
    always_comb begin
        c_addr   = addr_q;
        c_wdata  = wdata_q;
        c_we     = we_q;
        c_be     = be_q;
        complete = 1'b0;
        if (state == IDLE) begin
            c_addr  = dmem_addr;
            c_wdata = dmem_dataout;
            c_we    = dmem_we;
            c_be    = be_in;
            complete = NO_WAIT && dmem_req;
        end else if (state == BUSY) begin
            complete = (cnt == 4'd1);
        end
        c_idx = c_addr[AW+1:2];
        c_err = (c_addr[1:0] != 2'b00) || (c_addr >= ADDR_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst && complete && c_we && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            dmem_ready  <= 1'b0;
            dmem_err    <= 1'b0;
            dmem_datain <= '0;
        end else begin
            dmem_ready <= 1'b0;
            dmem_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (dmem_req) begin
                        addr_q  <= dmem_addr;
                        wdata_q <= dmem_dataout;
                        we_q    <= dmem_we;
                        be_q    <= be_in;
                        cnt     <= WAIT_INIT;
                        state   <= NO_WAIT ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // Stores never touch dmem_datain; an errored load returns zero.
            if (complete) begin
                dmem_ready <= 1'b1;
                dmem_err   <= c_err;
                if (!c_we) dmem_datain <= c_err ? '0 : mem[c_idx];
            end
        end
    end

endmodule
